instr_loader: RTL
=================

Name: instr_loader

Overview:
- Boot-time writer for the instruction memory that fetch_instr reads.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver.
- Parses a framed program image and writes 32-bit words to instruction memory starting at word address 0.
- Holds the RV32I core in reset while a load is in progress.

Parameters:
- NUM_INSTR, 1024, instruction memory depth in words; largest legal word count.
- ADDR_W, 10, width of the word address (clog2 of NUM_INSTR).
- HOLD_AT_RESET, 1, if 1 core_hold is 1 out of reset until the first successful load; if 0 core_hold is 0 out of reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- byte_in  input  8  incoming stream byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts byte_in this cycle.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  word being written.
- core_hold  output  1  high means the core is held in reset (drive core n_rst = ~core_hold).
- load_done  output  1  last load completed successfully (sticky).
- load_err  output  1  last load was aborted (sticky).

Behaviour:
- The only reset is rst: synchronous, active-high, single clock clk.
- Reset values:
  - State is IDLE.
  - byte_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - load_done=0, load_err=0.
  - core_hold=HOLD_AT_RESET.
  - Word counter and byte counter are 0.
- A byte is accepted only on a cycle with byte_valid && byte_ready.
- Frame format: magic 0xA5, LEN_LO, LEN_HI (16-bit word count N), then N words of 4 bytes each, little-endian (first byte is bits 7:0).
- States and transitions:
  - IDLE: any byte other than 0xA5 is accepted and discarded. 0xA5 -> LEN_LO; on that cycle core_hold=1 and load_done and load_err clear to 0.
  - LEN_LO: store byte as N[7:0] -> LEN_HI.
  - LEN_HI: store byte as N[15:8].
    - If N > NUM_INSTR -> ERR.
    - Else if N == 0 -> CSUM when CHECKSUM_EN is defined, otherwise DONE.
    - Else -> DATA with byte counter 0 and word address 0.
  - DATA: accept 4 bytes into the assembly register. On the 4th byte -> WRITE.
  - WRITE: lasts one cycle.
    - imem_we=1, imem_addr = current word index, imem_wdata = {b3,b2,b1,b0}.
    - byte_ready=0 in this state only.
    - Then the word index increments. If it now equals N -> CSUM or DONE, else -> DATA.
  - DONE: load_done=1, and core_hold=0 from the cycle after DONE is entered. byte_ready=1. Bytes are handled as in IDLE, so 0xA5 starts a new load.
  - ERR: load_err=1, core_hold stays 1. Non-magic bytes are discarded; 0xA5 restarts exactly as from IDLE.
- Latency:
  - imem_we asserts the cycle after the 4th byte of a word is accepted.
  - Maximum throughput is 4 bytes per 5 cycles.
- Address rules:
  - imem_addr never exceeds NUM_INSTR-1.
  - Words beyond N are never written.
  - Memory above address N-1 is left untouched.
- imem_wdata holds its last value when imem_we=0.
- N == NUM_INSTR is legal and fills the memory exactly; N == NUM_INSTR+1 goes to ERR without writing anything.
- A rst asserted mid-load aborts immediately to reset values; a partially written memory is not cleared.
- byte_valid held low indefinitely: the FSM waits in its current state; there is no timeout.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word (or straight after LEN_HI when N=0) the FSM enters CSUM and accepts one byte.
  - Pass condition: the XOR of LEN_LO, LEN_HI and every data byte, XORed with the checksum byte, equals 0x00.
  - Pass -> DONE. Mismatch -> ERR; words already written remain in memory.
- Not defined: no CSUM state; the frame ends after the last data byte.

Test Plan:
- Magic, N=2, words 0x00500093 and 0x00A00113 -> two imem_we pulses: addr0=0x00500093, addr1=0x00A00113. load_done=1, and core_hold falls to 0 the cycle after DONE.
- Bytes 0x00, 0x37, 0xFF, then a valid frame with N=1 and word 0xDEADBEEF -> the leading bytes are ignored; exactly one write, addr0=0xDEADBEEF.
- Magic, LEN=0x0401 (1025) -> ERR: load_err=1, no imem_we pulses, core_hold=1. A following valid frame recovers and sets load_done=1.
- Magic, N=0 -> DONE with no writes (with CHECKSUM_EN, a checksum byte of 0xA5^... must be sent as 0x00^0x00=0x00).
- rst pulsed after 2 data bytes of word 1 -> all outputs return to reset values; a fresh frame then loads correctly.
- CHECKSUM_EN defined: N=1, word 0x11223344, checksum 0x45 (0x01^0x00^0x44^0x33^0x22^0x11) -> DONE. A checksum of 0x46 -> ERR, with addr0 already written as 0x11223344.

Source files
------------

// File: rtl/instr_loader.sv
// Boot-time instruction memory loader: parses a 0xA5/LEN/data byte frame and writes 32-bit words from address 0.
// Optional trailing checksum byte enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int NUM_INSTR     = 1024,
  parameter int ADDR_W        = 10,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  // state  | meaning
  // IDLE   | waiting for magic, other bytes discarded
  // LEN_LO | expecting word count bits 7:0
  // LEN_HI | expecting word count bits 15:8, range-checked here
  // DATA   | assembling a little-endian word
  // WRITE  | one-cycle memory write, byte stream stalled
  // CSUM   | expecting the checksum byte (optional)
  // DONE   | load succeeded, core released
  // ERR    | load aborted, core held
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
`ifdef INSTR_LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  localparam logic [7:0]  MAGIC = 8'hA5;
  localparam logic [15:0] MAX_N = 16'(NUM_INSTR);

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CSUM;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t      state, state_nxt;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] assem;
  logic        accept;
  logic        magic_hit;
  logic [15:0] len_full;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign byte_ready = (state != WRITE);
  assign imem_we    = (state == WRITE);
  assign accept     = byte_valid && byte_ready;
  assign magic_hit  = accept && (byte_in == MAGIC);
  assign len_full   = {byte_in, len[7:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (magic_hit) state_nxt = LEN_LO;
      LEN_LO:          if (accept) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (len_full > MAX_N)       state_nxt = ERR;
          else if (len_full == 16'd0) state_nxt = END_STATE;
          else                        state_nxt = DATA;
        end
      end
      DATA:  if (accept && byte_cnt == 2'd3) state_nxt = WRITE;
      WRITE: state_nxt = ((word_idx + 16'd1) == len) ? END_STATE : DATA;
`ifdef INSTR_LOADER_CHECKSUM_EN
      CSUM:  if (accept) state_nxt = ((csum ^ byte_in) == 8'h00) ? DONE : ERR;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      assem      <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      core_hold  <= HOLD_AT_RESET;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt == DONE && state != DONE) load_done <= 1'b1;
      if (state_nxt == ERR && state != ERR)   load_err  <= 1'b1;
      // Release lags DONE entry by one cycle; a new magic below re-asserts it.
      if (state == DONE) core_hold <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (magic_hit) begin
            core_hold <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum      <= 8'h00;
`endif
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_in;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_in;
`endif
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= byte_in;
            word_idx  <= '0;
            byte_cnt  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum      <= csum ^ byte_in;
`endif
          end
        end
        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_in;
`endif
            case (byte_cnt)
              2'd0: assem[7:0]   <= byte_in;
              2'd1: assem[15:8]  <= byte_in;
              2'd2: assem[23:16] <= byte_in;
              default: begin
                // Latch address and data here so they hold stable after the write.
                imem_wdata <= {byte_in, assem};
                imem_addr  <= word_idx[ADDR_W-1:0];
              end
            endcase
          end
        end
        WRITE:   word_idx <= word_idx + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
